// File: rtl/mem_wb_stage_if.sv
// MEM/WB stage bus: MEM-side stage inputs, pipeline control and writeback/bypass outputs.
interface mem_wb_stage_if #(
  parameter int unsigned COUNT_W = 32
);
  // Pipeline control
  logic               stall;
  logic               flush;
  // MEM stage results
  logic               in_valid;
  logic               mem_to_reg;
  logic               reg_write;
  logic [31:0]        read_data;
  logic [31:0]        address;
  logic [4:0]         write_back_destination;
  logic [1:0]         load_mode;
  // Register-file write port
  logic               wb_reg_write;
  logic [4:0]         wb_write_register;
  logic [31:0]        wb_write_data;
  // One-cycle bypass copy of the last committed write
  logic               fwd_valid;
  logic [4:0]         fwd_register;
  logic [31:0]        fwd_data;
  // Status
  logic               align_err;
  logic [COUNT_W-1:0] retired_count;

  modport master (
    output stall, flush, in_valid, mem_to_reg, reg_write, read_data, address,
           write_back_destination, load_mode,
    input  wb_reg_write, wb_write_register, wb_write_data, fwd_valid, fwd_register, fwd_data,
           align_err, retired_count
  );

  modport slave (
    input  stall, flush, in_valid, mem_to_reg, reg_write, read_data, address,
           write_back_destination, load_mode,
    output wb_reg_write, wb_write_register, wb_write_data, fwd_valid, fwd_register, fwd_data,
           align_err, retired_count
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback stage: load alignment/extension, writeback select,
// register-file write port, one-cycle bypass copy and retired-instruction counter.
module mem_wb_stage #(
  parameter int unsigned COUNT_W = 32
) (
  input logic           clk,
  input logic           rst_n,
  mem_wb_stage_if.slave bus
);

  logic [15:0]        w_half;
  logic [7:0]         w_byte;
  logic [31:0]        w_load_data;
  logic [31:0]        w_wb_data;
  logic               w_align_err;
  logic               w_advance;

  logic               r_wb_valid;
  logic               r_reg_write;
  logic [4:0]         r_dest;
  logic [31:0]        r_data;
  logic               r_align_err;
  logic               r_fwd_valid;
  logic [4:0]         r_fwd_register;
  logic [31:0]        r_fwd_data;
  logic [COUNT_W-1:0] r_retired;

  // Little-endian load alignment and extension; misaligned low address bits are ignored.
  always_comb begin
    w_half = bus.address[1] ? bus.read_data[31:16] : bus.read_data[15:0];
    w_byte = 8'h00;
    unique case (bus.address[1:0])
      2'b00: w_byte = bus.read_data[7:0];
      2'b01: w_byte = bus.read_data[15:8];
      2'b10: w_byte = bus.read_data[23:16];
      2'b11: w_byte = bus.read_data[31:24];
      default: w_byte = 8'h00;
    endcase
    w_load_data = bus.read_data;
    unique case (bus.load_mode)
      2'b00: w_load_data = bus.read_data;
      2'b01: w_load_data = {{16{w_half[15]}}, w_half};
      2'b10: w_load_data = {16'h0000, w_half};
      2'b11: w_load_data = {{24{w_byte[7]}}, w_byte};
      default: w_load_data = bus.read_data;
    endcase
    w_wb_data   = bus.mem_to_reg ? w_load_data : bus.address;
    w_align_err = bus.mem_to_reg & bus.in_valid &
                  (((bus.load_mode == 2'b00) & (bus.address[1:0] != 2'b00)) |
                   (((bus.load_mode == 2'b01) | (bus.load_mode == 2'b10)) & bus.address[0]));
    // Flush overrides stall: the current entry leaves WB and a bubble replaces it.
    w_advance   = bus.flush | ~bus.stall;
  end

  // MEM/WB pipeline register: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wb_valid  <= 1'b0;
      r_reg_write <= 1'b0;
      r_dest      <= 5'd0;
      r_data      <= 32'd0;
      r_align_err <= 1'b0;
    end else if (bus.flush) begin
      r_wb_valid  <= 1'b0;
      r_reg_write <= 1'b0;
      r_dest      <= 5'd0;
      r_data      <= 32'd0;
      r_align_err <= 1'b0;
    end else if (!bus.stall) begin
      r_wb_valid  <= bus.in_valid;
      r_reg_write <= bus.reg_write;
      r_dest      <= bus.write_back_destination;
      r_data      <= w_wb_data;
      r_align_err <= w_align_err;
    end
  end

  // Bypass copy of the write committed on this edge; cleared while the stage is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fwd_valid    <= 1'b0;
      r_fwd_register <= 5'd0;
      r_fwd_data     <= 32'd0;
    end else if (w_advance) begin
      r_fwd_valid    <= bus.wb_reg_write;
      r_fwd_register <= r_dest;
      r_fwd_data     <= r_data;
    end else begin
      r_fwd_valid    <= 1'b0;
    end
  end

  // Retired-instruction counter: a valid entry retires whenever it leaves WB; wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retired <= '0;
    end else if (r_wb_valid && w_advance) begin
      r_retired <= r_retired + COUNT_W'(1);
    end
  end

  // Writes to $0 never reach the register file.
  assign bus.wb_reg_write      = r_wb_valid & r_reg_write & (r_dest != 5'd0);
  assign bus.wb_write_register = r_dest;
  assign bus.wb_write_data     = r_data;
  assign bus.fwd_valid         = r_fwd_valid;
  assign bus.fwd_register      = r_fwd_register;
  assign bus.fwd_data          = r_fwd_data;
  assign bus.align_err         = r_align_err;
  assign bus.retired_count     = r_retired;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage (default counter width plus a 4-bit wrap copy).
module tb_mem_wb_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  mem_wb_stage_if #(.COUNT_W(32)) bus ();
  mem_wb_stage_if #(.COUNT_W(4))  bus4 ();

  mem_wb_stage #(.COUNT_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  mem_wb_stage #(.COUNT_W(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle 1 time unit before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic valid, input logic m2r, input logic rw, input logic [31:0] rd,
                       input logic [31:0] addr, input logic [4:0] dest, input logic [1:0] mode);
    bus.in_valid               = valid;
    bus.mem_to_reg             = m2r;
    bus.reg_write              = rw;
    bus.read_data              = rd;
    bus.address                = addr;
    bus.write_back_destination = dest;
    bus.load_mode              = mode;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    bus.stall = 1'b0;
    bus.flush = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    bus4.stall = 1'b0;
    bus4.flush = 1'b0;
    bus4.in_valid = 1'b0;
    bus4.mem_to_reg = 1'b0;
    bus4.reg_write = 1'b1;
    bus4.read_data = 32'd0;
    bus4.address = 32'h0000_0100;
    bus4.write_back_destination = 5'd1;
    bus4.load_mode = 2'b00;
    step();
    step();
    rst_n = 1'b1;

    // Load real traffic, then reset mid-cycle: everything clears at once.
    drive(1'b1, 1'b0, 1'b1, $urandom, $urandom, 5'd7, 2'b00);
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wb_reg_write", {31'd0, bus.wb_reg_write}, 32'd0);
    chk("rst_wb_write_register", {27'd0, bus.wb_write_register}, 32'd0);
    chk("rst_wb_write_data", bus.wb_write_data, 32'd0);
    chk("rst_fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
    chk("rst_fwd_register", {27'd0, bus.fwd_register}, 32'd0);
    chk("rst_fwd_data", bus.fwd_data, 32'd0);
    chk("rst_align_err", {31'd0, bus.align_err}, 32'd0);
    chk("rst_retired_count", bus.retired_count, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 5'd0, 2'b00);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_retired", bus.retired_count, 32'd0);

    // lb, byte 1 and byte 2 (sign-extended).
    drive(1'b1, 1'b1, 1'b1, 32'h12F4_5678, 32'h0000_1001, 5'd8, 2'b11);
    step();
    chk("lb1_data", bus.wb_write_data, 32'h0000_0056);
    chk("lb1_we", {31'd0, bus.wb_reg_write}, 32'd1);
    chk("lb1_reg", {27'd0, bus.wb_write_register}, 32'd8);
    chk("lb1_align", {31'd0, bus.align_err}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h12F4_5678, 32'h0000_1002, 5'd8, 2'b11);
    step();
    chk("lb2_data", bus.wb_write_data, 32'hFFFF_FFF4);
    chk("lb2_fwd_valid", {31'd0, bus.fwd_valid}, 32'd1);
    chk("lb2_fwd_reg", {27'd0, bus.fwd_register}, 32'd8);
    chk("lb2_fwd_data", bus.fwd_data, 32'h0000_0056);

    // Halfword loads and misalignment.
    drive(1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 32'h0000_2002, 5'd9, 2'b10);
    step();
    chk("lhu_data", bus.wb_write_data, 32'h0000_8001);
    chk("lhu_align", {31'd0, bus.align_err}, 32'd0);
    drive(1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 32'h0000_2002, 5'd9, 2'b01);
    step();
    chk("lh_data", bus.wb_write_data, 32'hFFFF_8001);
    drive(1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 32'h0000_2003, 5'd9, 2'b01);
    step();
    chk("lh_mis_align", {31'd0, bus.align_err}, 32'd1);
    chk("lh_mis_data", bus.wb_write_data, 32'hFFFF_8001);
    drive(1'b1, 1'b1, 1'b1, 32'h8001_7FFF, 32'h0000_2001, 5'd9, 2'b00);
    step();
    chk("lw_mis_align", {31'd0, bus.align_err}, 32'd1);
    chk("lw_mis_data", bus.wb_write_data, 32'h8001_7FFF);

    // ALU writeback: $0 suppressed, then a real write and its one-cycle bypass.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd0, 2'b00);
    step();
    chk("r0_we", {31'd0, bus.wb_reg_write}, 32'd0);
    chk("alu_align", {31'd0, bus.align_err}, 32'd0);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'hDEAD_BEEF, 5'd5, 2'b00);
    step();
    chk("r5_we", {31'd0, bus.wb_reg_write}, 32'd1);
    chk("r5_reg", {27'd0, bus.wb_write_register}, 32'd5);
    chk("r5_data", bus.wb_write_data, 32'hDEAD_BEEF);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    step();
    chk("r5_fwd_valid", {31'd0, bus.fwd_valid}, 32'd1);
    chk("r5_fwd_reg", {27'd0, bus.fwd_register}, 32'd5);
    chk("r5_fwd_data", bus.fwd_data, 32'hDEAD_BEEF);
    chk("bubble_we", {31'd0, bus.wb_reg_write}, 32'd0);
    step();
    chk("r5_fwd_drop", {31'd0, bus.fwd_valid}, 32'd0);
    chk("retired_8", bus.retired_count, 32'd8);

    // Three back-to-back instructions, two-cycle stall while the 2nd sits in WB.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_000A, 5'd10, 2'b00);
    step();
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_000B, 5'd11, 2'b00);
    step();
    chk("stall_b_data", bus.wb_write_data, 32'h0000_000B);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_000C, 5'd12, 2'b00);
    bus.stall = 1'b1;
    step();
    chk("stall1_reg", {27'd0, bus.wb_write_register}, 32'd11);
    chk("stall1_data", bus.wb_write_data, 32'h0000_000B);
    chk("stall1_fwd_valid", {31'd0, bus.fwd_valid}, 32'd0);
    chk("stall1_retired", bus.retired_count, 32'd9);
    step();
    chk("stall2_data", bus.wb_write_data, 32'h0000_000B);
    chk("stall2_retired", bus.retired_count, 32'd9);
    bus.stall = 1'b0;
    step();
    chk("unstall_c_data", bus.wb_write_data, 32'h0000_000C);
    chk("unstall_fwd_reg", {27'd0, bus.fwd_register}, 32'd11);
    chk("unstall_fwd_valid", {31'd0, bus.fwd_valid}, 32'd1);
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    step();
    chk("stall_seq_retired", bus.retired_count, 32'd11);

    // Flush together with stall: bubble enters, current entry still retires.
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_000D, 5'd13, 2'b00);
    step();
    chk("pre_flush_we", {31'd0, bus.wb_reg_write}, 32'd1);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_000E, 5'd14, 2'b00);
    bus.flush = 1'b1;
    bus.stall = 1'b1;
    step();
    chk("flush_we", {31'd0, bus.wb_reg_write}, 32'd0);
    chk("flush_data", bus.wb_write_data, 32'd0);
    chk("flush_retired", bus.retired_count, 32'd12);
    bus.flush = 1'b0;
    bus.stall = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 2'b00);
    step();
    chk("post_flush_retired", bus.retired_count, 32'd12);

    // 17 retirements through a 4-bit counter wrap to 1.
    chk("wrap_start", {28'd0, bus4.retired_count}, 32'd0);
    bus4.in_valid = 1'b1;
    repeat (17) step();
    bus4.in_valid = 1'b0;
    step();
    chk("wrap_count", {28'd0, bus4.retired_count}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
